// File: rtl/serial_adder_subtractor.sv
`default_nettype none
// ============================================================================
// serial_adder_subtractor : digit-serial two's-complement add/sub, LSB first
// Revision 1.0 - initial release
// ============================================================================
module serial_adder_subtractor #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             subtract,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Result,
  output logic             Cout,
  output logic             Overflow,
  output logic             Zero
);

  localparam int L     = WIDTH / DIGIT;
  localparam int CNT_W = (L > 1) ? $clog2(L) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(L - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state, state_next;

  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic             carry;
  logic             a_msb;
  logic             b_msb;
  logic [CNT_W-1:0] cnt;

  logic             accept;
  logic             last;
  logic [DIGIT:0]   digit_sum;
  logic [WIDTH-1:0] a_next;

  // a_sh doubles as the result register: sum digits enter at the top as
  // operand digits leave at the bottom, so after L steps it holds the result.
  always_comb begin
    accept    = start && (state != BUSY);
    last      = (state == BUSY) && (cnt == LAST);
    digit_sum = {1'b0, a_sh[DIGIT-1:0]} + {1'b0, b_sh[DIGIT-1:0]}
              + {{DIGIT{1'b0}}, carry};
  end

  generate
    if (DIGIT == WIDTH) begin : g_full
      assign a_next = digit_sum[DIGIT-1:0];
    end else begin : g_part
      assign a_next = {digit_sum[DIGIT-1:0], a_sh[WIDTH-1:DIGIT]};
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_next = BUSY;
        end
      end
      BUSY: begin
        busy = 1'b1;
        if (cnt == LAST) begin
          state_next = DONE;
        end
      end
      DONE: begin
        done       = 1'b1;
        state_next = start ? BUSY : IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_sh     <= '0;
      b_sh     <= '0;
      carry    <= 1'b0;
      a_msb    <= 1'b0;
      b_msb    <= 1'b0;
      cnt      <= '0;
      Result   <= '0;
      Cout     <= 1'b0;
      Overflow <= 1'b0;
      Zero     <= 1'b0;
    end else if (accept) begin
      // Subtraction is A + ~B + 1: invert B up front and seed the carry.
      a_sh  <= A;
      b_sh  <= B ^ {WIDTH{subtract}};
      carry <= subtract;
      a_msb <= A[WIDTH-1];
      b_msb <= B[WIDTH-1] ^ subtract;
      cnt   <= '0;
    end else if (state == BUSY) begin
      a_sh  <= a_next;
      b_sh  <= b_sh >> DIGIT;
      carry <= digit_sum[DIGIT];
      cnt   <= cnt + 1'b1;
      if (last) begin
        Result   <= a_next;
        Cout     <= digit_sum[DIGIT];
        Overflow <= (a_msb == b_msb) && (a_next[WIDTH-1] != a_msb);
        Zero     <= (a_next == '0);
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_serial_adder_subtractor.sv
`default_nettype none
// ============================================================================
// tb_serial_adder_subtractor : scoreboard bench, WIDTH=4 and WIDTH=8 x DIGIT
// Revision 1.0 - initial release
// ============================================================================
module tb_serial_adder_subtractor;

  typedef struct {
    logic [7:0] res;
    logic       cout;
    logic       ovf;
    logic       zero;
    int         e0;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst4, start4, sub4;
  logic [3:0] a4, b4;
  logic       busy4, done4, cout4, ovf4, zero4;
  logic [3:0] res4;

  logic       rst8, start8, sub8;
  logic [7:0] a8, b8;
  logic       busy8 [4];
  logic       done8 [4];
  logic       cout8 [4];
  logic       ovf8  [4];
  logic       zero8 [4];
  logic [7:0] res8  [4];

  int   cyc = 0;
  int   tests = 0;
  int   fails = 0;
  int   rd [4] = '{default: 0};
  exp_t q4[$];
  exp_t q8[$];
  exp_t em;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  serial_adder_subtractor #(.WIDTH(4), .DIGIT(1)) u_dut4 (
    .clk(clk), .rst(rst4), .start(start4), .A(a4), .B(b4), .subtract(sub4),
    .busy(busy4), .done(done4), .Result(res4), .Cout(cout4),
    .Overflow(ovf4), .Zero(zero4)
  );

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_d8
      serial_adder_subtractor #(.WIDTH(8), .DIGIT(1 << gi)) u_dut (
        .clk(clk), .rst(rst8), .start(start8), .A(a8), .B(b8), .subtract(sub8),
        .busy(busy8[gi]), .done(done8[gi]), .Result(res8[gi]), .Cout(cout8[gi]),
        .Overflow(ovf8[gi]), .Zero(zero8[gi])
      );
    end
  endgenerate

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic exp_t model8(input logic [7:0] a, input logic [7:0] b, input logic s);
    logic [7:0] bx;
    logic [8:0] sm;
    exp_t       m;
    bx     = b ^ {8{s}};
    sm     = {1'b0, a} + {1'b0, bx} + {8'b0, s};
    m.res  = sm[7:0];
    m.cout = sm[8];
    m.ovf  = (a[7] == bx[7]) && (sm[7] != a[7]);
    m.zero = (sm[7:0] == 8'h00);
    m.e0   = 0;
    return m;
  endfunction

  // Issue one 4-bit op and wait through its L=4 busy edges.
  task automatic op4(input logic [3:0] a, input logic [3:0] b, input logic s,
                     input logic [3:0] r, input logic c, input logic o, input logic z);
    q4.push_back('{res: {4'b0, r}, cout: c, ovf: o, zero: z, e0: cyc + 1});
    a4 = a; b4 = b; sub4 = s; start4 = 1'b1;
    @(posedge clk); #1 start4 = 1'b0;
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic s,
                     input logic [7:0] r, input logic c, input logic o, input logic z);
    q8.push_back('{res: r, cout: c, ovf: o, zero: z, e0: cyc + 1});
    a8 = a; b8 = b; sub8 = s; start8 = 1'b1;
    @(posedge clk); #1 start8 = 1'b0;
    repeat (8) @(posedge clk);
    #1;
  endtask

  initial begin
    rst4 = 1'b1; rst8 = 1'b1; start4 = 1'b0; start8 = 1'b0;
    a4 = '0; b4 = '0; sub4 = 1'b0; a8 = '0; b8 = '0; sub8 = 1'b0;
    fork
      begin : drv
        logic [3:0] ha [3];
        logic [3:0] hb [3];
        logic       hs [3];
        logic [3:0] hr [3];
        logic       hc [3];
        logic       ho [3];
        logic       hz [3];
        exp_t       m;

        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_busy", busy4, 0);
        check("rst_done", done4, 0);
        check("rst_result", res4, 0);
        check("rst_cout", cout4, 0);
        check("rst_ovf", ovf4, 0);
        check("rst_zero", zero4, 0);
        check("rst8_result", res8[3], 0);
        @(posedge clk); #1 rst4 = 1'b0; rst8 = 1'b0;
        @(posedge clk); #1;

        // Busy window and output hold around the first op.
        q4.push_back('{res: 8'h09, cout: 1'b0, ovf: 1'b1, zero: 1'b0, e0: cyc + 1});
        a4 = 4'b0100; b4 = 4'b0101; sub4 = 1'b0; start4 = 1'b1;
        @(posedge clk); #1 start4 = 1'b0;
        for (int i = 0; i < 4; i++) begin
          @(negedge clk);
          check("t1_busy", busy4, 1);
          if (i == 2) check("t1_hold_result", res4, 0);
        end
        @(negedge clk);
        check("t1_busy_after", busy4, 0);
        @(posedge clk); #1;

        op4(4'b1111, 4'b1111, 1'b0, 4'b1110, 1'b1, 1'b0, 1'b0);
        op4(4'b1111, 4'b1111, 1'b1, 4'b0000, 1'b1, 1'b0, 1'b1);
        op4(4'b0010, 4'b0011, 1'b1, 4'b1111, 1'b0, 1'b0, 1'b0);
        op4(4'b0000, 4'b1111, 1'b1, 4'b0001, 1'b0, 1'b0, 1'b0);
        op4(4'b1000, 4'b0001, 1'b1, 4'b0111, 1'b1, 1'b1, 1'b0);

        // Disturb inputs while busy; outputs must still show the previous op.
        q4.push_back('{res: 8'h08, cout: 1'b0, ovf: 1'b1, zero: 1'b0, e0: cyc + 1});
        a4 = 4'b0110; b4 = 4'b0010; sub4 = 1'b0; start4 = 1'b1;
        @(posedge clk); #1 a4 = 4'b1111; b4 = 4'b1111; sub4 = 1'b1; start4 = 1'b1;
        @(negedge clk);
        check("t4_hold_result", res4, 4'b0111);
        check("t4_hold_cout", cout4, 1);
        @(posedge clk); #1 start4 = 1'b0; a4 = 4'b0000;
        repeat (3) @(posedge clk);
        #1;

        // start held high: one op every L+1 cycles, operands taken at acceptance.
        ha = '{4'b1010, 4'b0011, 4'b0111}; hb = '{4'b0110, 4'b0001, 4'b1001};
        hs = '{1'b0, 1'b0, 1'b1};          hr = '{4'b0000, 4'b0100, 4'b1110};
        hc = '{1'b1, 1'b0, 1'b0};          ho = '{1'b0, 1'b0, 1'b1};
        hz = '{1'b1, 1'b0, 1'b0};
        for (int i = 0; i < 3; i++) begin
          q4.push_back('{res: {4'b0, hr[i]}, cout: hc[i], ovf: ho[i], zero: hz[i], e0: cyc + 1});
          a4 = ha[i]; b4 = hb[i]; sub4 = hs[i]; start4 = 1'b1;
          @(posedge clk); #1 a4 = ~a4; b4 = ~b4; sub4 = ~sub4;
          repeat (4) @(posedge clk);
          #1;
        end
        start4 = 1'b0;

        // Reset in the second busy cycle aborts silently.
        @(posedge clk); #1;
        a4 = 4'b0101; b4 = 4'b0001; sub4 = 1'b0; start4 = 1'b1;
        @(posedge clk); #1 start4 = 1'b0;
        @(posedge clk); #1 rst4 = 1'b1;
        @(posedge clk); #1 rst4 = 1'b0;
        @(negedge clk);
        check("t5_busy", busy4, 0);
        check("t5_done", done4, 0);
        check("t5_result", res4, 0);
        check("t5_cout", cout4, 0);
        check("t5_ovf", ovf4, 0);
        check("t5_zero", zero4, 0);
        repeat (6) @(posedge clk);
        #1;
        op4(4'b0101, 4'b0001, 1'b0, 4'b0110, 1'b0, 1'b0, 1'b0);

        // 8-bit instances, all DIGIT values in parallel.
        op8(8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1, 1'b0);
        op8(8'h00, 8'h01, 1'b1, 8'hFF, 1'b0, 1'b0, 1'b0);
        op8(8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1);
        op8(8'h80, 8'h01, 1'b1, 8'h7F, 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 10; i++) begin
          logic [7:0] ra, rb;
          logic       rs;
          ra = 8'($urandom_range(0, 255));
          rb = 8'($urandom_range(0, 255));
          rs = 1'($urandom_range(0, 1));
          m  = model8(ra, rb, rs);
          op8(ra, rb, rs, m.res, m.cout, m.ovf, m.zero);
        end
        repeat (3) @(posedge clk);
      end
      begin : mon
        forever begin
          @(negedge clk);
          if (done4) begin
            if (q4.size() == 0) begin
              tests++; fails++;
              $display("FAIL w4_unexpected_done: got done=1, expected no pending op (cycle %0d)", cyc);
            end else begin
              em = q4.pop_front();
              check("w4_latency", cyc, em.e0 + 4);
              check("w4_result", res4, em.res[3:0]);
              check("w4_cout", cout4, em.cout);
              check("w4_ovf", ovf4, em.ovf);
              check("w4_zero", zero4, em.zero);
            end
          end
          for (int k = 0; k < 4; k++) begin
            if (done8[k]) begin
              if (rd[k] >= q8.size()) begin
                tests++; fails++;
                $display("FAIL d%0d_unexpected_done: got done=1, expected no pending op (cycle %0d)", 1 << k, cyc);
              end else begin
                em = q8[rd[k]];
                rd[k]++;
                check($sformatf("d%0d_latency", 1 << k), cyc, em.e0 + (8 >> k));
                check($sformatf("d%0d_result", 1 << k), res8[k], em.res);
                check($sformatf("d%0d_cout", 1 << k), cout8[k], em.cout);
                check($sformatf("d%0d_ovf", 1 << k), ovf8[k], em.ovf);
                check($sformatf("d%0d_zero", 1 << k), zero8[k], em.zero);
              end
            end
          end
        end
      end
    join_any
    disable fork;
    check("w4_pending_ops", q4.size(), 0);
    for (int k = 0; k < 4; k++) begin
      check($sformatf("d%0d_completed_ops", 1 << k), rd[k], q8.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
